// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage with PC, 1-cycle imem requests, prefetch FIFO and redirect flush.
// Defining IFU_PERF_CNT_EN adds saturating fetch/redirect/stall counters.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 64,
    parameter int                INSTR_W    = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               imem_req_valid_o,
    output logic [ADDR_W-1:0]  imem_req_addr_o,
    input  logic [INSTR_W-1:0] imem_rsp_data_i,
    input  logic               redirect_valid_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [INSTR_W-1:0] instruction_o,
`ifdef IFU_PERF_CNT_EN
    output logic [ADDR_W-1:0]  PC_o,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_redirect_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`else
    output logic [ADDR_W-1:0]  PC_o
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_rsp_pc;
    logic               r_inflight;
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [PW:0]        r_count;
    logic [INSTR_W-1:0] r_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_pcs  [FIFO_DEPTH];
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [PW+1:0]      w_credit;

    // Occupancy after this edge, counting the word still in flight, must leave room for one more.
    assign w_valid  = r_count != '0;
    assign w_pop    = w_valid & ready_i;
    assign w_push   = r_inflight & ~redirect_valid_i;
    assign w_credit = {1'b0, r_count} + (PW+2)'(r_inflight) - (PW+2)'(w_pop);
    assign w_issue  = reset_i & ~redirect_valid_i & (w_credit < (PW+2)'(FIFO_DEPTH));

    assign imem_req_valid_o = w_issue;
    assign imem_req_addr_o  = r_pc;
    assign valid_o          = w_valid;
    assign instruction_o    = w_valid ? r_data[r_rptr] : '0;
    assign PC_o             = w_valid ? r_pcs[r_rptr] : '0;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (redirect_valid_i) begin
            r_pc       <= redirect_pc_i & ~ADDR_W'(3);
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_pc     <= r_pc + ADDR_W'(4);
                r_rsp_pc <= r_pc;
            end
            r_inflight <= w_issue;
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data[r_wptr] <= imem_rsp_data_i;
            r_pcs[r_wptr]  <= r_rsp_pc;
        end
    end

    assert property (@(posedge clk_i) disable iff (!reset_i)
        !(w_push && !w_pop && r_count == (PW+1)'(FIFO_DEPTH)));

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_issue && ~&r_fetch_cnt)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (redirect_valid_i && ~&r_redirect_cnt)
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            if (w_valid && !ready_i && ~&r_stall_cnt)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt_o    = r_fetch_cnt;
    assign perf_redirect_cnt_o = r_redirect_cnt;
    assign perf_stall_cnt_o    = r_stall_cnt;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + random redirect/backpressure stimulus; program-order scoreboard on the decode handshake.
module tb_instr_fetch_unit;
    localparam int AW = 64;
    localparam int IW = 32;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          imem_req_valid_o;
    logic [AW-1:0] imem_req_addr_o;
    logic [IW-1:0] imem_rsp_data_i;
    logic          redirect_valid_i = 1'b0;
    logic [AW-1:0] redirect_pc_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [IW-1:0] instruction_o;
    logic [AW-1:0] PC_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]   perf_fetch_cnt_o;
    logic [31:0]   perf_redirect_cnt_o;
    logic [31:0]   perf_stall_cnt_o;
`endif

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(4), .RESET_PC('0)) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_addr_o(imem_req_addr_o),
        .imem_rsp_data_i(imem_rsp_data_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .instruction_o(instruction_o),
`ifdef IFU_PERF_CNT_EN
        .PC_o(PC_o),
        .perf_fetch_cnt_o(perf_fetch_cnt_o),
        .perf_redirect_cnt_o(perf_redirect_cnt_o),
        .perf_stall_cnt_o(perf_stall_cnt_o)
`else
        .PC_o(PC_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] hash(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic redirect(input logic [63:0] t);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = t;
        step();
        redirect_valid_i = 1'b0;
    endtask

    // Instruction memory: answers only issued requests, garbage otherwise.
    logic          r_mem_ok = 1'b0;
    logic [AW-1:0] r_mem_addr = '0;
    always @(posedge clk_i) begin
        r_mem_ok   <= imem_req_valid_o;
        r_mem_addr <= imem_req_addr_o;
    end
    assign imem_rsp_data_i = r_mem_ok ? hash(r_mem_addr) : 32'hDEAD_BEEF;

    // Reference: decode must see the program in order from the last reset/redirect target.
    logic [63:0] exp_q[$];
    logic [63:0] gen_pc = '0;
    logic [63:0] e;
    int          idle = 0;
    int          t_fetch = 0, t_redir = 0, t_stall = 0;

    always @(negedge clk_i) begin
        if (!reset_i) begin
            exp_q.delete();
            gen_pc  = '0;
            idle    = 0;
            t_fetch = 0;
            t_redir = 0;
            t_stall = 0;
        end else begin
            if (redirect_valid_i)
                chk("no_req_in_redirect", {63'd0, imem_req_valid_o}, 64'd0);
            if (valid_o && ready_i) begin
                e = exp_q.pop_front();
                chk("hs_pc", PC_o, e);
                chk("hs_instr", {32'd0, instruction_o}, {32'd0, hash(e)});
            end
            if (redirect_valid_i) begin
                exp_q.delete();
                gen_pc = redirect_pc_i & ~64'd3;
            end
            idle = (ready_i && !valid_o) ? idle + 1 : 0;
            if (idle > 30) begin
                errors++;
                $display("FAIL watchdog no instruction delivered for %0d ready cycles", idle);
                idle = 0;
            end
            t_fetch += int'(imem_req_valid_o);
            t_redir += int'(redirect_valid_i);
            t_stall += int'(valid_o && !ready_i);
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(gen_pc);
            gen_pc += 64'd4;
        end
    end

    int issued;
    int hold_bad;
    int r;

    initial begin
        ready_i = 1'b1;
        step();
        step();
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        chk("rst_req_addr", imem_req_addr_o, 64'd0);
        chk("rst_instr", {32'd0, instruction_o}, 64'd0);
        chk("rst_pc", PC_o, 64'd0);
        reset_i = 1'b1;
        #1;
        chk("first_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        chk("first_req_addr", imem_req_addr_o, 64'd0);
        step();
        chk("edge1_valid", {63'd0, valid_o}, 64'd0);
        chk("edge1_req_addr", imem_req_addr_o, 64'd4);
        step();
        chk("edge2_valid", {63'd0, valid_o}, 64'd1);
        chk("edge2_pc", PC_o, 64'd0);
        step();
        chk("edge3_pc", PC_o, 64'd4);
        step();
        chk("edge4_pc", PC_o, 64'd8);

        reset_i = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, valid_o}, 64'd0);
        chk("midrst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        chk("midrst_req_addr", imem_req_addr_o, 64'd0);
        step();
        step();
        reset_i  = 1'b1;
        issued   = 0;
        hold_bad = 0;
        for (int i = 0; i < 11; i++) begin
            #1;
            issued += int'(imem_req_valid_o);
            step();
            if (valid_o && (PC_o != 64'd0 || instruction_o != hash(64'd0)))
                hold_bad++;
        end
        chk("stall_issue_count", 64'(issued), 64'd4);
        chk("stall_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        chk("stall_head_valid", {63'd0, valid_o}, 64'd1);
        chk("stall_head_pc", PC_o, 64'd0);
        chk("stall_hold_bad", 64'(hold_bad), 64'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("drain_valid", {63'd0, valid_o}, 64'd1);
            chk("drain_pc", PC_o, 64'(4 * i));
            step();
        end

        reset_i = 1'b0;
        ready_i = 1'b0;
        step();
        reset_i = 1'b1;
        repeat (4) step();
        chk("pre_redir_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        chk("pre_redir_valid", {63'd0, valid_o}, 64'd1);
        redirect(64'h100);
        chk("redir_valid_next", {63'd0, valid_o}, 64'd0);
        chk("redir_req_addr", imem_req_addr_o, 64'h100);
        step();
        chk("redir_valid_e1", {63'd0, valid_o}, 64'd0);
        step();
        chk("redir_valid_e2", {63'd0, valid_o}, 64'd1);
        chk("redir_pc0", PC_o, 64'h100);
        ready_i = 1'b1;
        step();
        chk("redir_pc1", PC_o, 64'h104);

        redirect(64'h203);
        chk("align_req_addr", imem_req_addr_o, 64'h200);
        step();
        step();
        chk("align_pc", PC_o, 64'h200);

        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h40;
        step();
        redirect(64'h80);
        chk("b2b_req_addr", imem_req_addr_o, 64'h80);
        step();
        step();
        chk("b2b_valid", {63'd0, valid_o}, 64'd1);
        chk("b2b_pc", PC_o, 64'h80);

        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_req_addr0", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_req_addr1", imem_req_addr_o, 64'h0);
        repeat (4) step();

        for (int i = 0; i < 3000; i++) begin
            ready_i = ($urandom % 10) < 7;
            r = int'($urandom % 100);
            redirect_valid_i = r < 4;
            if (r < 2)
                redirect_pc_i = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom % 256);
            else
                redirect_pc_i = {$urandom, $urandom};
            step();
        end
        redirect_valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (10) step();
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", {32'd0, perf_fetch_cnt_o}, 64'(t_fetch));
        chk("perf_redirect", {32'd0, perf_redirect_cnt_o}, 64'(t_redir));
        chk("perf_stall", {32'd0, perf_stall_cnt_o}, 64'(t_stall));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
